pl_spi_slave: RTL and testbench
===============================

# pl_spi_slave

SPI peripheral (slave) endpoint, mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames: the far end of the PL SPI master link. Sits in the PL between the SPI pins and the PS-facing register bank. It oversamples SCLK/CS/MOSI in the `i_Clk` domain and shifts received bytes into `o_RxBuffer`. It returns bytes queued by software from a small TX FIFO and reports progress through an 8-bit status register.

## Interface
- `TX_DEPTH`, default 4: TX FIFO depth in bytes, a power of 2, 2..16.
- `IDLE_FILL`, default 8'hFF: byte shifted out when the TX FIFO is empty.
- `i_Clk` input 1: FPGA clock. It must be at least 8× SCLK, so each SCLK half-period is at least 4 `i_Clk` cycles.
- `i_Rst_L` input 1: reset, synchronous, active-low.
- `i_SPI_Clk` input 1: SCLK from the master. It is asynchronous to `i_Clk`.
- `i_SPI_CS` input 1: chip select from the master, active-low, asynchronous.
- `i_SPI_MOSI` input 1: serial data from the master.
- `o_SPI_MISO` output 1: serial data to the master.
- `i_TxBuffer` input 8: byte to queue for transmission.
- `i_Tx_Wr` input 1: 1-cycle strobe that pushes `i_TxBuffer` into the FIFO. It is ignored when the FIFO is full.
- `i_Rx_Ack` input 1: 1-cycle strobe that clears RX_RDY.
- `i_Clr_Flags` input 1: 1-cycle strobe that clears OVR, UND, ABT and DONE.
- `o_RxBuffer` output 8: last complete received byte.
- `o_StatusReg` output 8: status bits.
  - [0] BUSY: synchronized CS is low.
  - [1] RX_RDY.
  - [2] OVR: RX overrun.
  - [3] TX_EMPTY.
  - [4] UND: TX underrun.
  - [5] ABT: CS deasserted mid-byte.
  - [6] TX_FULL.
  - [7] DONE: CS rose after at least one byte.
- `o_Rx_Cnt` output 8: bytes received in the current/last frame. It wraps modulo 256.

## Operation
- **Input synchronization:** SCLK, CS and MOSI each pass through a 2-flop synchronizer plus one history flop. The synchronized edges are `sclk_rise`, `sclk_fall`, `cs_fall` and `cs_rise`.
- **FSM states:**
  - IDLE: CS high. MISO is driven 0 and the bit counter is 0.
  - LOAD: on `cs_fall`.
    - Pop the FIFO into the shift-out register. If the FIFO is empty, load IDLE_FILL and set UND.
    - Drive bit 7 on MISO. Clear `o_Rx_Cnt`. Go to SHIFT.
  - SHIFT:
    - On `sclk_rise`: shift the synchronized MOSI into the RX shift register LSB and increment the bit counter.
    - On `sclk_fall` with bit counter 1..7: drive the next TX bit.
    - When the bit counter reaches 8 (on `sclk_rise`):
      - Copy the RX shift register to `o_RxBuffer` and increment `o_Rx_Cnt`.
      - If RX_RDY is already set, set OVR; the new byte overwrites the old one.
      - Set RX_RDY and zero the counter.
      - On the following `sclk_fall`, perform the LOAD action for the next byte.
  - On `cs_rise` from LOAD/SHIFT:
    - A counter other than 0 sets ABT and discards the partial byte.
    - `o_Rx_Cnt` > 0 sets DONE.
    - Go to IDLE.
- **Flags:**
  - `i_Rx_Ack` clears RX_RDY. If it coincides with a new byte completing, the set wins.
  - `i_Clr_Flags` clears OVR, UND, ABT and DONE. If it coincides with a set event, the set wins.
- **TX FIFO:**
  - Simultaneous push and pop on a full FIFO: the pop is performed first, so the push is accepted.
  - Push on full is dropped, with no flag.
  - Pop on empty is never issued.

## Timing
- **Reset values:** `o_SPI_MISO`=0, `o_RxBuffer`=0, `o_StatusReg`=8'h08 (TX_EMPTY only), `o_Rx_Cnt`=0. The FIFO is empty and the FSM is in IDLE.
- **Reset mid-frame:** everything is aborted immediately with no flags set. If CS is still low after reset, the slave waits for the next `cs_fall`.
- **Pin-to-action latency:**
  - SCLK/CS pin edge to action: exactly 3 `i_Clk` cycles.
  - MISO update: within 3 cycles of the SCLK falling edge. It is therefore stable at least 1 cycle before the next rising edge, given the 4-cycle half-period minimum.
- **Register updates:**
  - `o_RxBuffer` and RX_RDY are valid on the cycle after the internal `sclk_rise` that completes bit 8.
  - All outputs are registered.
- **FIFO status:** TX_FULL and TX_EMPTY update on the cycle after the `i_Tx_Wr` or pop.
- **Inter-frame gap:** CS high for at least 4 `i_Clk` cycles between frames.

## Structure
- Shared package `pl_spi_pkg` holds:
  - Status bit index constants: `ST_BUSY` … `ST_DONE`.
  - The mode constants CPOL=0 and CPHA=0, shared with the master.
  - The FSM state encoding.
- Sub-module `pl_spi_tx_fifo`: synchronous FIFO with parameters DEPTH and WIDTH. It provides push, pop, full, empty and data-out with first-word fall-through.
- The top level contains the synchronizers, edge detect, FSM, shift registers and status logic.

## Test plan
- **Single byte:** push 8'hA5, run a master frame sending 8'h3C at 9-cycle half-bit → MISO stream reads 8'hA5, `o_RxBuffer`=8'h3C, RX_RDY=1, DONE=1, `o_Rx_Cnt`=1.
- **Multi-byte frame:** push 8'h11, 8'h22, 8'h33; one CS-low frame of 3 bytes with MOSI 8'h01, 8'h02, 8'h03 → MISO stream 11,22,33, last `o_RxBuffer`=8'h03, OVR=1 (no acks), `o_Rx_Cnt`=3, TX_EMPTY=1.
- **Underrun:** frame of 2 bytes with 1 byte queued (8'h5A) → MISO stream 5A,FF, UND=1.
- **Abort:** CS raised after 5 SCLK rising edges → ABT=1, `o_RxBuffer` unchanged, counter reset. The next full frame then receives correctly.
- **FIFO boundary:** push 5 bytes with TX_DEPTH=4 → TX_FULL=1 and the 5th byte is dropped. A push coincident with a pop while full is accepted.
- **Reset mid-frame:** `i_Rst_L`=0 during bit 4 → all outputs return to reset values the next cycle with no flags set. A fresh frame after release works.

Source files
------------

// File: rtl/pl_spi_pkg.sv
// pl_spi_pkg: constants shared by the PL SPI master and slave.
//   - SPI mode (CPOL/CPHA)
//   - status register bit positions
//   - slave FSM state encoding
package pl_spi_pkg;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  localparam int ST_BUSY   = 0;
  localparam int ST_RX_RDY = 1;
  localparam int ST_OVR    = 2;
  localparam int ST_TX_EMP = 3;
  localparam int ST_UND    = 4;
  localparam int ST_ABT    = 5;
  localparam int ST_TX_FUL = 6;
  localparam int ST_DONE   = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/pl_spi_slave_if.sv
// pl_spi_slave_if: SPI pins plus the register-bank side of the slave.
//   slave  modport : used by pl_spi_slave
//   master modport : used by whoever drives the pins / register bank
interface pl_spi_slave_if;
  logic       i_SPI_Clk;
  logic       i_SPI_CS;
  logic       i_SPI_MOSI;
  logic       o_SPI_MISO;
  logic [7:0] i_TxBuffer;
  logic       i_Tx_Wr;
  logic       i_Rx_Ack;
  logic       i_Clr_Flags;
  logic [7:0] o_RxBuffer;
  logic [7:0] o_StatusReg;
  logic [7:0] o_Rx_Cnt;

  modport slave (
    input  i_SPI_Clk, i_SPI_CS, i_SPI_MOSI, i_TxBuffer, i_Tx_Wr, i_Rx_Ack, i_Clr_Flags,
    output o_SPI_MISO, o_RxBuffer, o_StatusReg, o_Rx_Cnt
  );

  modport master (
    output i_SPI_Clk, i_SPI_CS, i_SPI_MOSI, i_TxBuffer, i_Tx_Wr, i_Rx_Ack, i_Clr_Flags,
    input  o_SPI_MISO, o_RxBuffer, o_StatusReg, o_Rx_Cnt
  );
endinterface

// File: rtl/pl_spi_tx_fifo.sv
// pl_spi_tx_fifo: synchronous first-word-fall-through FIFO.
//   clk/rst_l : clock, synchronous active-low reset
//   push/din  : write strobe and data (dropped when full unless popping)
//   pop       : read strobe (ignored when empty)
//   full/empty: registered status, valid the cycle after push/pop
//   dout      : head of queue
module pl_spi_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;

  // Pop is resolved first so a push on a full FIFO with a pop is accepted.
  always_comb begin
    do_pop   = pop & ~empty_q;
    do_push  = push & (~full_q | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    full_d   = (cnt_d == (AW+1)'(DEPTH));
    empty_d  = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign dout  = mem_q[rd_ptr_q];
endmodule

// File: rtl/pl_spi_slave.sv
// pl_spi_slave: SPI mode-0 slave, MSB first, 8-bit frames.
//   i_Clk   : system clock, >= 8x SCLK
//   i_Rst_L : synchronous active-low reset
//   bus     : SPI pins, TX push, RX ack, flag clear, RX byte, status, RX count
module pl_spi_slave
  import pl_spi_pkg::*;
#(
  parameter int         TX_DEPTH  = 4,
  parameter logic [7:0] IDLE_FILL = 8'hFF
) (
  input  logic           i_Clk,
  input  logic           i_Rst_L,
  pl_spi_slave_if.slave  bus
);
  // {mosi, cs, sclk}; history kept for cs and sclk only
  logic [2:0] meta_q, meta_d, sync_q, sync_d;
  logic [1:0] hist_q, hist_d;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise, mosi;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d, rx_buf_q, rx_buf_d, rx_cnt_q, rx_cnt_d;
  logic       miso_q, miso_d, busy_q, busy_d, rx_rdy_q, rx_rdy_d;
  logic       ovr_q, ovr_d, und_q, und_d, abt_q, abt_d, done_q, done_d;
  logic       load, pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;

  pl_spi_tx_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (i_Clk),
    .rst_l (i_Rst_L),
    .push  (bus.i_Tx_Wr),
    .din   (bus.i_TxBuffer),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign sclk_rise =  sync_q[0] & ~hist_q[0];
  assign sclk_fall = ~sync_q[0] &  hist_q[0];
  assign cs_fall   = ~sync_q[1] &  hist_q[1];
  assign cs_rise   =  sync_q[1] & ~hist_q[1];
  assign mosi      =  sync_q[2];

  always_comb begin
    meta_d    = {bus.i_SPI_MOSI, bus.i_SPI_CS, bus.i_SPI_Clk};
    sync_d    = meta_q;
    hist_d    = sync_q[1:0];
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    miso_d    = miso_q;
    rx_buf_d  = rx_buf_q;
    rx_cnt_d  = rx_cnt_q;
    busy_d    = ~sync_q[1];
    // clears first; any set below overrides them
    rx_rdy_d  = rx_rdy_q & ~bus.i_Rx_Ack;
    ovr_d     = ovr_q  & ~bus.i_Clr_Flags;
    und_d     = und_q  & ~bus.i_Clr_Flags;
    abt_d     = abt_q  & ~bus.i_Clr_Flags;
    done_d    = done_q & ~bus.i_Clr_Flags;
    load      = 1'b0;

    case (state_q)
      S_IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = '0;
        if (cs_fall) state_d = S_LOAD;
      end
      default: begin
        if (cs_rise) begin
          if (bit_cnt_q != '0) abt_d = 1'b1;
          if (state_q == S_SHIFT && rx_cnt_q != '0) done_d = 1'b1;
          state_d   = S_IDLE;
          miso_d    = 1'b0;
          bit_cnt_d = '0;
        end else if (state_q == S_LOAD) begin
          load     = 1'b1;
          rx_cnt_d = '0;
          state_d  = S_SHIFT;
        end else if (sclk_rise) begin
          rx_sr_d = {rx_sr_q[6:0], mosi};
          if (bit_cnt_q == 3'd7) begin
            rx_buf_d  = rx_sr_d;
            rx_cnt_d  = rx_cnt_q + 8'd1;
            if (rx_rdy_q) ovr_d = 1'b1;
            rx_rdy_d  = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (sclk_fall) begin
          // a fall with the counter at 0 follows a completed byte
          if (bit_cnt_q == '0) begin
            load = 1'b1;
          end else begin
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
            miso_d  = tx_sr_q[6];
          end
        end
      end
    endcase

    pop = load & ~fifo_empty;
    if (load) begin
      tx_sr_d = fifo_empty ? IDLE_FILL : fifo_dout;
      miso_d  = tx_sr_d[7];
      if (fifo_empty) und_d = 1'b1;
    end
  end

  // Synchronizers run through reset so they always track the pins; a frame
  // already in progress at reset release produces no false cs_fall.
  always_ff @(posedge i_Clk) begin
    meta_q <= meta_d;
    sync_q <= sync_d;
    hist_q <= hist_d;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      rx_sr_q   <= '0;
      tx_sr_q   <= '0;
      miso_q    <= 1'b0;
      rx_buf_q  <= '0;
      rx_cnt_q  <= '0;
      busy_q    <= 1'b0;
      rx_rdy_q  <= 1'b0;
      ovr_q     <= 1'b0;
      und_q     <= 1'b0;
      abt_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sr_q   <= rx_sr_d;
      tx_sr_q   <= tx_sr_d;
      miso_q    <= miso_d;
      rx_buf_q  <= rx_buf_d;
      rx_cnt_q  <= rx_cnt_d;
      busy_q    <= busy_d;
      rx_rdy_q  <= rx_rdy_d;
      ovr_q     <= ovr_d;
      und_q     <= und_d;
      abt_q     <= abt_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    bus.o_StatusReg            = '0;
    bus.o_StatusReg[ST_BUSY]   = busy_q;
    bus.o_StatusReg[ST_RX_RDY] = rx_rdy_q;
    bus.o_StatusReg[ST_OVR]    = ovr_q;
    bus.o_StatusReg[ST_TX_EMP] = fifo_empty;
    bus.o_StatusReg[ST_UND]    = und_q;
    bus.o_StatusReg[ST_ABT]    = abt_q;
    bus.o_StatusReg[ST_TX_FUL] = fifo_full;
    bus.o_StatusReg[ST_DONE]   = done_q;
  end

  assign bus.o_SPI_MISO = miso_q;
  assign bus.o_RxBuffer = rx_buf_q;
  assign bus.o_Rx_Cnt   = rx_cnt_q;
endmodule

// File: tb/tb_pl_spi_slave.sv
// tb_pl_spi_slave: directed + randomized frames against a byte-level model.
module tb_pl_spi_slave;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  pl_spi_slave_if bus();

  pl_spi_slave #(.TX_DEPTH(4), .IDLE_FILL(8'hFF)) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_l),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0] m_q[$];
  logic [7:0] m_rxbuf;
  logic [7:0] m_rxcnt;
  logic       m_rdy, m_ovr, m_und, m_abt, m_done;
  logic [7:0] mq[$];   // MOSI bytes for the next frame

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] m_status();
    logic full, empty;
    full  = (m_q.size() == 4);
    empty = (m_q.size() == 0);
    return {m_done, full, m_abt, m_und, empty, m_ovr, m_rdy, 1'b0};
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_rxbuf = 8'h00; m_rxcnt = 8'h00;
    m_rdy = 0; m_ovr = 0; m_und = 0; m_abt = 0; m_done = 0;
  endtask

  task automatic push(input logic [7:0] b);
    bus.i_TxBuffer = b; bus.i_Tx_Wr = 1'b1;
    tick(1);
    bus.i_Tx_Wr = 1'b0;
    if (m_q.size() < 4) m_q.push_back(b);
  endtask

  task automatic ack();
    bus.i_Rx_Ack = 1'b1; tick(1); bus.i_Rx_Ack = 1'b0;
    m_rdy = 0;
  endtask

  task automatic clr();
    bus.i_Clr_Flags = 1'b1; tick(1); bus.i_Clr_Flags = 1'b0;
    m_ovr = 0; m_und = 0; m_abt = 0; m_done = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_rxbuf"},  bus.o_RxBuffer,  m_rxbuf);
    chk({tag, "_status"}, bus.o_StatusReg, m_status());
    chk({tag, "_rxcnt"},  bus.o_Rx_Cnt,    m_rxcnt);
  endtask

  // One CS-low frame of nbits SCLK cycles, MOSI from mq. Optionally pushes
  // cbyte in the same cycle as the frame's first FIFO pop.
  task automatic frame(input string tag, input int nbits, input int half,
                       input bit cpush, input logic [7:0] cbyte);
    logic [7:0] ld[$];
    int nfull, part;
    logic [7:0] g, msk;
    nfull = nbits / 8;
    part  = nbits % 8;
    // model: one load at CS fall, one after every completed byte
    for (int l = 0; l <= nfull; l++) begin
      if (m_q.size() == 0) begin m_und = 1; ld.push_back(8'hFF); end
      else ld.push_back(m_q.pop_front());
      if (l == 0 && cpush && m_q.size() < 4) m_q.push_back(cbyte);
    end
    m_rxcnt = 8'h00;
    for (int j = 0; j < nfull; j++) begin
      if (m_rdy) m_ovr = 1;
      m_rdy = 1; m_rxbuf = mq[j]; m_rxcnt = m_rxcnt + 8'd1;
    end
    if (part != 0) m_abt = 1;
    if (nfull != 0) m_done = 1;

    bus.i_SPI_MOSI = mq[0][7];
    bus.i_SPI_CS   = 1'b0;
    if (cpush) begin
      tick(3);
      bus.i_TxBuffer = cbyte; bus.i_Tx_Wr = 1'b1;
      tick(1);
      bus.i_Tx_Wr = 1'b0;
      tick(half - 4);
    end else begin
      tick(half);
    end
    chk({tag, "_busy"}, bus.o_StatusReg[0], 1'b1);
    g = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      g = {g[6:0], bus.o_SPI_MISO};
      if (i % 8 == 7) chk({tag, "_miso"}, g, ld[i / 8]);
      bus.i_SPI_Clk = 1'b1;
      tick(half);
      bus.i_SPI_Clk = 1'b0;
      if (i + 1 < nbits) bus.i_SPI_MOSI = mq[(i + 1) / 8][7 - ((i + 1) % 8)];
      tick(half);
    end
    if (part != 0) begin
      msk = (8'h01 << part) - 8'h01;
      chk({tag, "_miso_part"}, g & msk, ld[nfull] >> (8 - part));
    end
    bus.i_SPI_CS = 1'b1;
    tick(10);
    chk({tag, "_miso_idle"}, bus.o_SPI_MISO, 1'b0);
    check_regs(tag);
  endtask

  initial begin
    int nb, half, np;
    bus.i_SPI_Clk = 1'b0; bus.i_SPI_CS = 1'b1; bus.i_SPI_MOSI = 1'b0;
    bus.i_TxBuffer = 8'h00; bus.i_Tx_Wr = 1'b0; bus.i_Rx_Ack = 1'b0; bus.i_Clr_Flags = 1'b0;
    m_reset();
    rst_l = 1'b0;
    tick(3);
    chk("rst_miso", bus.o_SPI_MISO, 1'b0);
    check_regs("rst");
    rst_l = 1'b1;
    tick(5);

    // single byte
    push(8'hA5);
    mq = '{8'h3C};
    frame("single", 8, 9, 1'b0, 8'h00);
    ack(); clr();

    // multi-byte, no acks -> overrun
    push(8'h11); push(8'h22); push(8'h33);
    mq = '{8'h01, 8'h02, 8'h03};
    frame("multi", 24, 5, 1'b0, 8'h00);
    ack(); clr();

    // underrun
    push(8'h5A);
    mq = '{8'hC6, 8'h39};
    frame("under", 16, 6, 1'b0, 8'h00);
    ack(); clr();

    // abort after 5 bits, then a clean frame
    push(8'hE7);
    mq = '{8'hB2};
    frame("abort", 5, 4, 1'b0, 8'h00);
    clr();
    push(8'h4D);
    mq = '{8'h96};
    frame("post_abort", 8, 4, 1'b0, 8'h00);
    ack(); clr();

    // FIFO boundary: 5th push dropped, push coincident with pop while full
    for (int k = 0; k < 5; k++) push(8'h81 + 8'(k));
    chk("fifo_full", bus.o_StatusReg[6], 1'b1);
    chk("fifo_status", bus.o_StatusReg, m_status());
    mq = '{8'h0F};
    frame("coinc", 8, 5, 1'b1, 8'h99);
    ack(); clr();
    mq = '{8'h10, 8'h20, 8'h30, 8'h40};
    frame("drain", 32, 4, 1'b0, 8'h00);
    ack(); clr();

    // reset during bit 4
    push(8'h77);
    bus.i_SPI_MOSI = 1'b1; bus.i_SPI_CS = 1'b0;
    tick(5);
    for (int i = 0; i < 4; i++) begin
      bus.i_SPI_Clk = 1'b1; tick(5); bus.i_SPI_Clk = 1'b0; tick(5);
    end
    rst_l = 1'b0;
    tick(1);
    m_reset();
    chk("midrst_miso", bus.o_SPI_MISO, 1'b0);
    check_regs("midrst");
    rst_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_SPI_Clk = 1'b1; tick(5); bus.i_SPI_Clk = 1'b0; tick(5);
    end
    bus.i_SPI_CS = 1'b1;
    tick(10);
    check_regs("after_rst");
    push(8'h3E);
    mq = '{8'hD4};
    frame("fresh", 8, 5, 1'b0, 8'h00);

    // randomized frames
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) ack();
      if ($urandom_range(0, 2) == 0) clr();
      np = $urandom_range(0, 5);
      for (int k = 0; k < np; k++) push(8'($urandom));
      chk("rnd_pre_status", bus.o_StatusReg, m_status());
      if ($urandom_range(0, 3) == 0) nb = $urandom_range(1, 23);
      else nb = 8 * $urandom_range(1, 3);
      half = $urandom_range(4, 10);
      mq.delete();
      for (int k = 0; k < (nb + 7) / 8; k++) mq.push_back(8'($urandom));
      frame("rnd", nb, half, ($urandom_range(0, 4) == 0), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
